// File: rtl/bayer_pattern_source_pkg.sv
// Shared definitions for the synthetic Bayer stream source: word type codes,
// FSM states, pattern selectors and a small width helper.
package bayer_pattern_source_pkg;

  localparam int DTYPE_WIDTH = 3;

  localparam logic [DTYPE_WIDTH-1:0] DTYPE_NONE        = 3'd0;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 3'd1;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 3'd2;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 3'd3;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 3'd4;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FSTART,
    ST_RSTART,
    ST_PIX,
    ST_REND,
    ST_HBLANK,
    ST_FEND,
    ST_VBLANK
  } state_t;

  typedef enum logic [1:0] {
    PAT_CONST   = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_COUNTER = 2'd2,
    PAT_FRAME   = 2'd3
  } pattern_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bayer_pattern_value.sv
// Combinational pixel generator: maps pattern selector, position, running
// index and frame count to one pixel value. The caller registers the result.
module bayer_pattern_value
  import bayer_pattern_source_pkg::*;
#(
  parameter int PIXEL_WIDTH    = 8,
  parameter int NUM_ROWS_WIDTH = 12,
  parameter int NUM_COLS_WIDTH = 12
) (
  input  logic [1:0]                i_pattern,
  input  logic [NUM_ROWS_WIDTH-1:0] i_row,
  input  logic [NUM_COLS_WIDTH-1:0] i_col,
  input  logic [PIXEL_WIDTH-1:0]    i_ch00,
  input  logic [PIXEL_WIDTH-1:0]    i_ch01,
  input  logic [PIXEL_WIDTH-1:0]    i_ch10,
  input  logic [PIXEL_WIDTH-1:0]    i_ch11,
  input  logic [PIXEL_WIDTH-1:0]    i_pixIdx,
  input  logic [PIXEL_WIDTH-1:0]    i_frameCount,
  output logic [PIXEL_WIDTH-1:0]    o_pixel
);

  // One extra bit so the ramp sum never overflows before truncation.
  localparam int SUM_W = maxInt(NUM_ROWS_WIDTH, NUM_COLS_WIDTH) + 1;

  logic [SUM_W-1:0]       w_sum;
  logic [PIXEL_WIDTH-1:0] w_chan;

  assign w_sum = SUM_W'(i_row) + SUM_W'(i_col);

  always_comb begin
    w_chan = i_ch00;
    case ({i_row[0], i_col[0]})
      2'b00: w_chan = i_ch00;
      2'b01: w_chan = i_ch01;
      2'b10: w_chan = i_ch10;
      2'b11: w_chan = i_ch11;
      default: w_chan = i_ch00;
    endcase
  end

  always_comb begin
    o_pixel = '0;
    case (pattern_t'(i_pattern))
      PAT_CONST:   o_pixel = w_chan;
      PAT_RAMP:    o_pixel = PIXEL_WIDTH'(w_sum);
      PAT_COUNTER: o_pixel = i_pixIdx;
      PAT_FRAME:   o_pixel = i_frameCount;
      default:     o_pixel = '0;
    endcase
  end

endmodule

// File: rtl/bayer_pattern_source.sv
// Synthetic Bayer pixel-stream transmitter: emits framed rows of deterministic
// patterns with configurable geometry and blanking, replacing the sensor front end.
module bayer_pattern_source
  import bayer_pattern_source_pkg::*;
#(
  parameter int PIXEL_WIDTH    = 8,
  parameter int NUM_ROWS_WIDTH = 12,
  parameter int NUM_COLS_WIDTH = 12,
  parameter int BLANK_WIDTH    = 16
) (
  input  logic                      pixclk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_ROWS_WIDTH-1:0] num_rows,
  input  logic [NUM_COLS_WIDTH-1:0] num_cols,
  input  logic [BLANK_WIDTH-1:0]    hblank,
  input  logic [BLANK_WIDTH-1:0]    vblank,
  input  logic [1:0]                pattern,
  input  logic [PIXEL_WIDTH-1:0]    ch00,
  input  logic [PIXEL_WIDTH-1:0]    ch01,
  input  logic [PIXEL_WIDTH-1:0]    ch10,
  input  logic [PIXEL_WIDTH-1:0]    ch11,
  output logic                      dvo,
  output logic [DTYPE_WIDTH-1:0]    dtypeo,
  output logic [PIXEL_WIDTH-1:0]    datao,
  output logic                      busy,
  output logic [15:0]               frame_count
);

  localparam logic [NUM_ROWS_WIDTH-1:0] ROW_ONE   = 1;
  localparam logic [NUM_COLS_WIDTH-1:0] COL_ONE   = 1;
  localparam logic [BLANK_WIDTH-1:0]    BLANK_ONE = 1;
  localparam logic [PIXEL_WIDTH-1:0]    PIX_ONE   = 1;

  state_t r_state;

  logic [NUM_ROWS_WIDTH-1:0] r_numRows;
  logic [NUM_COLS_WIDTH-1:0] r_numCols;
  logic [BLANK_WIDTH-1:0]    r_hblank;
  logic [BLANK_WIDTH-1:0]    r_vblank;
  logic [1:0]                r_pattern;
  logic [PIXEL_WIDTH-1:0]    r_ch00;
  logic [PIXEL_WIDTH-1:0]    r_ch01;
  logic [PIXEL_WIDTH-1:0]    r_ch10;
  logic [PIXEL_WIDTH-1:0]    r_ch11;

  logic [NUM_ROWS_WIDTH-1:0] r_row;
  logic [NUM_COLS_WIDTH-1:0] r_col;
  logic [BLANK_WIDTH-1:0]    r_blankCnt;
  logic [PIXEL_WIDTH-1:0]    r_pixIdx;

  logic                      r_dvo;
  logic [DTYPE_WIDTH-1:0]    r_dtype;
  logic [PIXEL_WIDTH-1:0]    r_data;
  logic                      r_busy;
  logic [15:0]               r_frameCount;

  logic                      w_lastCol;
  logic                      w_lastRow;
  logic                      w_lastH;
  logic                      w_lastV;
  logic                      w_frameDone;
  logic                      w_loadCfg;
  logic [PIXEL_WIDTH-1:0]    w_pixel;

  assign w_lastCol = (r_col == (r_numCols - COL_ONE));
  assign w_lastRow = (r_row == (r_numRows - ROW_ONE));
  assign w_lastH   = (r_blankCnt == (r_hblank - BLANK_ONE));
  assign w_lastV   = (r_blankCnt == (r_vblank - BLANK_ONE));

  // A frame is done either at the last vblank cycle or straight out of FEND when vblank is 0.
  assign w_frameDone = ((r_state == ST_VBLANK) && w_lastV) ||
                       ((r_state == ST_FEND) && (r_vblank == '0));
  assign w_loadCfg   = enable && ((r_state == ST_IDLE) || w_frameDone);

  bayer_pattern_value #(
    .PIXEL_WIDTH   (PIXEL_WIDTH),
    .NUM_ROWS_WIDTH(NUM_ROWS_WIDTH),
    .NUM_COLS_WIDTH(NUM_COLS_WIDTH)
  ) u_value (
    .i_pattern   (r_pattern),
    .i_row       (r_row),
    .i_col       (r_col),
    .i_ch00      (r_ch00),
    .i_ch01      (r_ch01),
    .i_ch10      (r_ch10),
    .i_ch11      (r_ch11),
    .i_pixIdx    (r_pixIdx),
    .i_frameCount(r_frameCount[PIXEL_WIDTH-1:0]),
    .o_pixel     (w_pixel)
  );

  // Shadow config is captured only at frame boundaries so mid-frame edits wait a frame.
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_numRows <= ROW_ONE;
      r_numCols <= COL_ONE;
      r_hblank  <= '0;
      r_vblank  <= '0;
      r_pattern <= '0;
      r_ch00    <= '0;
      r_ch01    <= '0;
      r_ch10    <= '0;
      r_ch11    <= '0;
    end else if (w_loadCfg) begin
      r_numRows <= (num_rows == '0) ? ROW_ONE : num_rows;
      r_numCols <= (num_cols == '0) ? COL_ONE : num_cols;
      r_hblank  <= hblank;
      r_vblank  <= vblank;
      r_pattern <= pattern;
      r_ch00    <= ch00;
      r_ch01    <= ch01;
      r_ch10    <= ch10;
      r_ch11    <= ch11;
    end
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_blankCnt   <= '0;
      r_pixIdx     <= '0;
      r_dvo        <= 1'b0;
      r_dtype      <= DTYPE_NONE;
      r_data       <= '0;
      r_busy       <= 1'b0;
      r_frameCount <= '0;
    end else begin
      r_dvo   <= 1'b0;
      r_dtype <= DTYPE_NONE;
      r_data  <= '0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (enable) r_state <= ST_FSTART;
        end
        ST_FSTART: begin
          r_dvo    <= 1'b1;
          r_dtype  <= DTYPE_FRAME_START;
          r_busy   <= 1'b1;
          r_row    <= '0;
          r_pixIdx <= '0;
          r_state  <= ST_RSTART;
        end
        ST_RSTART: begin
          r_dvo   <= 1'b1;
          r_dtype <= DTYPE_ROW_START;
          r_col   <= '0;
          r_state <= ST_PIX;
        end
        ST_PIX: begin
          r_dvo    <= 1'b1;
          r_dtype  <= DTYPE_PIXEL;
          r_data   <= w_pixel;
          r_pixIdx <= r_pixIdx + PIX_ONE;
          if (w_lastCol) r_state <= ST_REND;
          else           r_col   <= r_col + COL_ONE;
        end
        ST_REND: begin
          r_dvo   <= 1'b1;
          r_dtype <= DTYPE_ROW_END;
          if (w_lastRow) begin
            r_state <= ST_FEND;
          end else begin
            r_row <= r_row + ROW_ONE;
            if (r_hblank != '0) begin
              r_blankCnt <= '0;
              r_state    <= ST_HBLANK;
            end else begin
              r_state <= ST_RSTART;
            end
          end
        end
        ST_HBLANK: begin
          if (w_lastH) r_state    <= ST_RSTART;
          else         r_blankCnt <= r_blankCnt + BLANK_ONE;
        end
        ST_FEND: begin
          r_dvo        <= 1'b1;
          r_dtype      <= DTYPE_FRAME_END;
          r_frameCount <= r_frameCount + 16'd1;
          if (r_vblank != '0) begin
            r_blankCnt <= '0;
            r_state    <= ST_VBLANK;
          end else begin
            r_state <= enable ? ST_FSTART : ST_IDLE;
          end
        end
        ST_VBLANK: begin
          if (w_lastV) r_state    <= enable ? ST_FSTART : ST_IDLE;
          else         r_blankCnt <= r_blankCnt + BLANK_ONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dvo         = r_dvo;
  assign dtypeo      = r_dtype;
  assign datao       = r_data;
  assign busy        = r_busy;
  assign frame_count = r_frameCount;

endmodule

// File: tb/tb_bayer_pattern_source.sv
// Self-checking bench for bayer_pattern_source: a frame model fills a scoreboard
// queue of expected per-cycle words, compared as the DUT emits its stream.
module tb_bayer_pattern_source;
  import bayer_pattern_source_pkg::*;

  localparam int PW = 8;
  localparam int RW = 12;
  localparam int CW = 12;
  localparam int BW = 16;

  logic                   pixclk = 1'b0;
  logic                   reset  = 1'b0;
  logic                   enable = 1'b0;
  logic [RW-1:0]          num_rows = '0;
  logic [CW-1:0]          num_cols = '0;
  logic [BW-1:0]          hblank = '0;
  logic [BW-1:0]          vblank = '0;
  logic [1:0]             pattern = '0;
  logic [PW-1:0]          ch00 = 8'd10;
  logic [PW-1:0]          ch01 = 8'd20;
  logic [PW-1:0]          ch10 = 8'd30;
  logic [PW-1:0]          ch11 = 8'd40;
  logic                   dvo;
  logic [DTYPE_WIDTH-1:0] dtypeo;
  logic [PW-1:0]          datao;
  logic                   busy;
  logic [15:0]            frame_count;

  always #5 pixclk = ~pixclk;

  bayer_pattern_source #(
    .PIXEL_WIDTH(PW), .NUM_ROWS_WIDTH(RW), .NUM_COLS_WIDTH(CW), .BLANK_WIDTH(BW)
  ) dut (
    .pixclk(pixclk), .reset(reset), .enable(enable),
    .num_rows(num_rows), .num_cols(num_cols), .hblank(hblank), .vblank(vblank),
    .pattern(pattern), .ch00(ch00), .ch01(ch01), .ch10(ch10), .ch11(ch11),
    .dvo(dvo), .dtypeo(dtypeo), .datao(datao), .busy(busy), .frame_count(frame_count)
  );

  typedef struct packed {
    logic                   dvo;
    logic [DTYPE_WIDTH-1:0] dtype;
    logic [PW-1:0]          data;
  } word_t;

  typedef struct {
    int rows; int cols; int hb; int vb; int pat;
    int expPix; int expFrames;
  } vec_t;

  word_t sbQueue[$];
  vec_t  vecs[6];
  int    chVals[4];

  int checks = 0;
  int errors = 0;
  bit sbRun = 0;
  bit sbStarted = 0;
  int sbIndex = 0;
  int pixCount = 0;
  int rsCount = 0;
  int fsCount = 0;

  // Reference pixel value, written from the pattern definitions.
  function automatic logic [PW-1:0] modelPixel(input int pat, input int r, input int c,
                                               input int idx, input int fc);
    case (pat)
      0:       return PW'(chVals[(r % 2) * 2 + (c % 2)]);
      1:       return PW'((r + c) % 256);
      2:       return PW'(idx % 256);
      default: return PW'(fc % 256);
    endcase
  endfunction

  task automatic pushWord(input logic v, input logic [DTYPE_WIDTH-1:0] t, input logic [PW-1:0] d);
    word_t w;
    w.dvo = v; w.dtype = t; w.data = d;
    sbQueue.push_back(w);
  endtask

  // Expected cycle-by-cycle stream of one frame, starting at its FRAME_START word.
  task automatic pushFrame(input int rows, input int cols, input int hb, input int vb,
                           input int pat, input int fc);
    int nr = (rows == 0) ? 1 : rows;
    int nc = (cols == 0) ? 1 : cols;
    int idx = 0;
    pushWord(1'b1, DTYPE_FRAME_START, '0);
    for (int r = 0; r < nr; r++) begin
      pushWord(1'b1, DTYPE_ROW_START, '0);
      for (int c = 0; c < nc; c++) begin
        pushWord(1'b1, DTYPE_PIXEL, modelPixel(pat, r, c, idx, fc));
        idx++;
      end
      pushWord(1'b1, DTYPE_ROW_END, '0);
      if (r != nr - 1)
        for (int k = 0; k < hb; k++) pushWord(1'b0, DTYPE_NONE, '0);
    end
    pushWord(1'b1, DTYPE_FRAME_END, '0);
    for (int k = 0; k < vb; k++) pushWord(1'b0, DTYPE_NONE, '0);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int rows, input int cols, input int hb, input int vb,
                               input int pat);
    num_rows = RW'(rows);
    num_cols = CW'(cols);
    hblank   = BW'(hb);
    vblank   = BW'(vb);
    pattern  = 2'(pat);
  endtask

  task automatic startScoreboard();
    sbQueue.delete();
    sbStarted = 0; sbIndex = 0;
    pixCount = 0; rsCount = 0; fsCount = 0;
    sbRun = 1;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (sbQueue.size() != 0 && n < budget) begin
      @(posedge pixclk);
      n++;
    end
    checkOutput({name, " stream drained"}, sbQueue.size(), 0);
    sbRun = 0;
    sbQueue.delete();
  endtask

  task automatic waitBusy(input string name, input int budget);
    int n = 0;
    while (!busy && n < budget) begin
      @(negedge pixclk);
      n++;
    end
    checkOutput({name, " busy rose"}, int'(busy), 1);
  endtask

  task automatic quietCheck(input string name, input int cycles);
    int bad = 0;
    repeat (cycles) begin
      @(negedge pixclk);
      if (dvo !== 1'b0) bad++;
    end
    checkOutput({name, " dvo quiet cycles with dvo=1"}, bad, 0);
  endtask

  task automatic doReset();
    enable = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge pixclk);
    reset  = 1'b0;
  endtask

  // Scoreboard monitor: starts on the first valid word, then compares every cycle.
  initial begin
    word_t expW;
    word_t actW;
    forever begin
      @(negedge pixclk);
      if (sbRun) begin
        if (!sbStarted && dvo === 1'b1) sbStarted = 1;
        if (sbStarted && sbQueue.size() > 0) begin
          expW = sbQueue.pop_front();
          actW.dvo = dvo; actW.dtype = dtypeo; actW.data = datao;
          checks++;
          if (actW !== expW) begin
            errors++;
            $display("[TB] FAIL stream word %0d: got dvo=%b dtype=%0d data=%0d, expected dvo=%b dtype=%0d data=%0d",
                     sbIndex, actW.dvo, actW.dtype, actW.data, expW.dvo, expW.dtype, expW.data);
          end
          if (dvo === 1'b1 && dtypeo == DTYPE_PIXEL)       pixCount++;
          if (dvo === 1'b1 && dtypeo == DTYPE_ROW_START)   rsCount++;
          if (dvo === 1'b1 && dtypeo == DTYPE_FRAME_START) fsCount++;
          sbIndex++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    chVals = '{10, 20, 30, 40};
    vecs[0] = '{rows: 4,  cols: 4,  hb: 2, vb: 3, pat: 0, expPix: 16,  expFrames: 1};
    vecs[1] = '{rows: 3,  cols: 5,  hb: 0, vb: 2, pat: 1, expPix: 15,  expFrames: 1};
    vecs[2] = '{rows: 0,  cols: 0,  hb: 1, vb: 1, pat: 2, expPix: 1,   expFrames: 1};
    vecs[3] = '{rows: 2,  cols: 3,  hb: 1, vb: 0, pat: 2, expPix: 6,   expFrames: 1};
    vecs[4] = '{rows: 5,  cols: 2,  hb: 0, vb: 0, pat: 3, expPix: 10,  expFrames: 1};
    vecs[5] = '{rows: 20, cols: 16, hb: 1, vb: 2, pat: 2, expPix: 320, expFrames: 1};

    #1 reset = 1'b1;
    repeat (3) @(negedge pixclk);
    checkOutput("reset dvo", int'(dvo), 0);
    checkOutput("reset dtypeo", int'(dtypeo), 0);
    checkOutput("reset datao", int'(datao), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset frame_count", int'(frame_count), 0);
    reset = 1'b0;

    // Single frames from the vector table.
    for (int i = 0; i < 6; i++) begin
      doReset();
      applyStimulus(vecs[i].rows, vecs[i].cols, vecs[i].hb, vecs[i].vb, vecs[i].pat);
      startScoreboard();
      pushFrame(vecs[i].rows, vecs[i].cols, vecs[i].hb, vecs[i].vb, vecs[i].pat, 0);
      enable = 1'b1;
      waitBusy($sformatf("vec%0d", i), 20);
      enable = 1'b0;
      waitDrain($sformatf("vec%0d", i), 2000);
      repeat (2) @(negedge pixclk);
      checkOutput($sformatf("vec%0d pixel count", i), pixCount, vecs[i].expPix);
      checkOutput($sformatf("vec%0d frame_count", i), int'(frame_count), vecs[i].expFrames);
      checkOutput($sformatf("vec%0d busy after frame", i), int'(busy), 0);
      quietCheck($sformatf("vec%0d", i), 8);
    end

    // Enable dropped during row 2 of an 8x8 frame: the frame still completes.
    doReset();
    applyStimulus(8, 8, 1, 2, 1);
    startScoreboard();
    pushFrame(8, 8, 1, 2, 1, 0);
    enable = 1'b1;
    n = 0;
    while (rsCount < 3 && n < 500) begin
      @(negedge pixclk);
      n++;
    end
    enable = 1'b0;
    checkOutput("enable drop reached row 2", int'(rsCount >= 3), 1);
    waitDrain("enable drop", 2000);
    repeat (2) @(negedge pixclk);
    checkOutput("enable drop busy", int'(busy), 0);
    checkOutput("enable drop frame_count", int'(frame_count), 1);
    checkOutput("enable drop pixel count", pixCount, 64);
    quietCheck("enable drop", 20);

    // num_cols edited mid-frame: applies only to the back-to-back next frame.
    doReset();
    applyStimulus(2, 4, 1, 2, 3);
    startScoreboard();
    pushFrame(2, 4, 1, 2, 3, 0);
    pushFrame(2, 6, 1, 2, 3, 1);
    enable = 1'b1;
    waitBusy("cols change", 20);
    num_cols = CW'(6);
    n = 0;
    while (fsCount < 2 && n < 300) begin
      @(negedge pixclk);
      n++;
    end
    enable = 1'b0;
    checkOutput("cols change second frame started", int'(fsCount >= 2), 1);
    waitDrain("cols change", 2000);
    repeat (2) @(negedge pixclk);
    checkOutput("cols change pixel count", pixCount, 20);
    checkOutput("cols change frame_count", int'(frame_count), 2);

    // Reset pulse while pixels are streaming: immediate clear, then a clean frame.
    applyStimulus(4, 4, 0, 0, 2);
    enable = 1'b1;
    n = 0;
    while (!(dvo === 1'b1 && dtypeo == DTYPE_PIXEL) && n < 100) begin
      @(negedge pixclk);
      n++;
    end
    checkOutput("mid-frame reached pixels", int'(dvo === 1'b1 && dtypeo == DTYPE_PIXEL), 1);
    enable = 1'b0;
    reset  = 1'b1;
    #1;
    checkOutput("mid-frame reset dvo", int'(dvo), 0);
    checkOutput("mid-frame reset dtypeo", int'(dtypeo), 0);
    checkOutput("mid-frame reset datao", int'(datao), 0);
    checkOutput("mid-frame reset busy", int'(busy), 0);
    checkOutput("mid-frame reset frame_count", int'(frame_count), 0);
    quietCheck("during reset", 4);
    @(negedge pixclk);
    reset = 1'b0;
    applyStimulus(2, 2, 0, 1, 0);
    startScoreboard();
    pushFrame(2, 2, 0, 1, 0, 0);
    enable = 1'b1;
    waitBusy("after reset", 20);
    enable = 1'b0;
    waitDrain("after reset", 500);
    repeat (2) @(negedge pixclk);
    checkOutput("after reset frame_count", int'(frame_count), 1);
    checkOutput("after reset pixel count", pixCount, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
